// File: rtl/uart_rx_frame_if.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_if
//   Bundles the serial line, the per-frame configuration and the received
//   byte / status pulses of the UART receive framer.
//
//   RX_IN       serial line, idles high
//   PAR_EN      1 = frame carries a parity bit
//   PAR_TYP     0 = even parity, 1 = odd parity
//   Prescale    clock cycles per bit (8, 16 or 32)
//   P_DATA      last correctly received byte
//   data_valid  one-cycle pulse, P_DATA holds a new good byte
//   par_err     one-cycle pulse, parity mismatch, frame dropped
//   stp_err     one-cycle pulse, stop bit sampled low, frame dropped
//
//   master: line/config driver side; slave: the receiver.
// ---------------------------------------------------------------------------
interface uart_rx_frame_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [PRESC_W-1:0]    Prescale;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP, Prescale,
        input  P_DATA, data_valid, par_err, stp_err
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, Prescale,
        output P_DATA, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_frame.sv
// ---------------------------------------------------------------------------
// uart_rx_frame
//   Oversampling UART receiver: start bit, DATA_WIDTH data bits LSB first,
//   optional parity bit, one stop bit. Each bit lasts Prescale cycles and is
//   resolved by a 2-of-3 majority around its middle.
//
//   CLK    oversampling clock (baud x Prescale)
//   RST    asynchronous active-low reset
//   rx_if  slave side of uart_rx_frame_if (line, config, byte, pulses)
//
//   state  | meaning
//   IDLE   | line idle, waiting for a low level to start a frame
//   START  | inside the start bit, rejecting glitches
//   DATA   | shifting in data bits, LSB first
//   PARITY | sampling the parity bit and comparing it
//   STOP   | sampling the stop bit, issuing data_valid / par_err / stp_err
// ---------------------------------------------------------------------------
module uart_rx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic            CLK,
    input  logic            RST,
    uart_rx_frame_if.slave  rx_if
);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [PRESC_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [1:0]            smp_q, smp_d;
    logic                  stop_bit_q, stop_bit_d;
    logic                  par_bad_q, par_bad_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic [PRESC_W-1:0]    half;
    logic                  at_smp0, at_smp1, at_res, at_wrap;
    logic                  maj;
    logic                  rx;

    assign rx      = rx_if.RX_IN;
    assign half    = presc_q >> 1;
    assign at_smp0 = (edge_cnt_q == half - PRESC_W'(1));
    assign at_smp1 = (edge_cnt_q == half);
    assign at_res  = (edge_cnt_q == half + PRESC_W'(1));
    assign at_wrap = (edge_cnt_q == presc_q - PRESC_W'(1));
    // Third sample is the live line value at the resolve edge.
    assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx) | (smp_q[1] & rx);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            presc_q      <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            smp_q        <= '0;
            stop_bit_q   <= 1'b0;
            par_bad_q    <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            presc_q      <= presc_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            smp_q        <= smp_d;
            stop_bit_q   <= stop_bit_d;
            par_bad_q    <= par_bad_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        presc_d      = presc_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        smp_d        = smp_q;
        stop_bit_d   = stop_bit_q;
        par_bad_d    = par_bad_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        if (state_q != IDLE) begin
            edge_cnt_d = at_wrap ? '0 : edge_cnt_q + PRESC_W'(1);
            if (at_smp0) smp_d[0] = rx;
            if (at_smp1) smp_d[1] = rx;
        end

        unique case (state_q)
            IDLE: begin
                if (!rx) begin
                    // Detect edge is edge 0 of the start bit.
                    state_d    = START;
                    edge_cnt_d = PRESC_W'(1);
                    bit_cnt_d  = '0;
                    par_bad_d  = 1'b0;
                    presc_d    = rx_if.Prescale;
                    par_en_d   = rx_if.PAR_EN;
                    par_typ_d  = rx_if.PAR_TYP;
                end
            end
            START: begin
                if (at_res && maj) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                end else if (at_wrap) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (at_res) shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
                if (at_wrap) begin
                    if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (at_res) par_bad_d = (maj != (par_typ_q ? ~^shift_q : ^shift_q));
                if (at_wrap) state_d = STOP;
            end
            STOP: begin
                if (at_res) stop_bit_d = maj;
                if (at_wrap) begin
                    // Stop error dominates a simultaneous parity error.
                    if (!stop_bit_q) begin
                        stp_err_d = 1'b1;
                    end else if (par_bad_q) begin
                        par_err_d = 1'b1;
                    end else begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                    if (!rx) begin
                        // Line already low: this edge is the next detect edge.
                        state_d    = START;
                        edge_cnt_d = PRESC_W'(1);
                        bit_cnt_d  = '0;
                        par_bad_d  = 1'b0;
                        presc_d    = rx_if.Prescale;
                        par_en_d   = rx_if.PAR_EN;
                        par_typ_d  = rx_if.PAR_TYP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

    assign rx_if.P_DATA     = p_data_q;
    assign rx_if.data_valid = data_valid_q;
    assign rx_if.par_err    = par_err_q;
    assign rx_if.stp_err    = stp_err_q;
endmodule

// File: tb/tb_uart_rx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame
//   Drives directed UART frames bit-slot by bit-slot and predicts, per frame,
//   which pulse appears and at which cycle (detect + N*P). A per-cycle
//   compare process checks all outputs against that prediction.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame;
    logic clk;
    logic rst_n;

    uart_rx_frame_if #(.DATA_WIDTH(8), .PRESC_W(6)) rif ();

    uart_rx_frame #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
        .CLK   (clk),
        .RST   (rst_n),
        .rx_if (rif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         pe;
        int         kind;   // 0 = data_valid, 1 = par_err, 2 = stp_err
        logic [7:0] data;
    } ev_t;

    ev_t        evq[$];
    int         dv_pe[$];
    int         pe;
    int         last_d;
    int         errors;
    int         checks;
    int         n_dv, n_par, n_stp;
    logic [7:0] exp_pdata;

    initial begin
        pe = 0; errors = 0; checks = 0;
        n_dv = 0; n_par = 0; n_stp = 0;
        exp_pdata = 8'h00;
        last_d = 0;
    end

    always @(posedge clk) pe++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (posedge %0d)", name, act, exp, pe);
        end
    endtask

    // Per-cycle comparison against the frame-level prediction.
    always @(negedge clk) begin
        logic [31:0] exp_v;
        logic [31:0] act_v;
        logic        e_dv, e_par, e_stp;
        ev_t         ev;
        e_dv = 1'b0; e_par = 1'b0; e_stp = 1'b0;
        if (!rst_n) begin
            exp_pdata = 8'h00;
        end else if (evq.size() > 0 && evq[0].pe == pe) begin
            ev = evq.pop_front();
            case (ev.kind)
                0: begin e_dv = 1'b1; exp_pdata = ev.data; end
                1: e_par = 1'b1;
                default: e_stp = 1'b1;
            endcase
        end
        exp_v = {21'd0, e_dv, e_par, e_stp, exp_pdata};
        act_v = {21'd0, rif.data_valid, rif.par_err, rif.stp_err, rif.P_DATA};
        chk("cycle_outputs", act_v, exp_v);
        if (rif.data_valid) begin n_dv++; dv_pe.push_back(pe); end
        if (rif.par_err) n_par++;
        if (rif.stp_err) n_stp++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rif.RX_IN = 1'b1;
        tick(n);
    endtask

    // par_bad: send the wrong parity bit; scramble: change config mid-frame;
    // abort_slot >= 0: assert reset halfway through that bit slot.
    task automatic send_frame(input logic [7:0] d, input bit pen, input bit ptyp,
                              input int p, input bit par_bad, input bit stop_v,
                              input bit scramble, input int abort_slot);
        logic bits [0:10];
        int   nslots;
        int   kind;
        nslots = pen ? 11 : 10;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        bits[9] = (^d) ^ ptyp ^ par_bad;
        bits[10] = 1'b1;
        bits[nslots-1] = stop_v;
        kind = !stop_v ? 2 : ((pen && par_bad) ? 1 : 0);
        rif.PAR_EN   = pen;
        rif.PAR_TYP  = ptyp;
        rif.Prescale = 6'(p);
        last_d = pe + 1;
        if (abort_slot < 0) evq.push_back('{last_d + nslots * p - 1, kind, d});
        for (int s = 0; s < nslots; s++) begin
            rif.RX_IN = bits[s];
            if (s == abort_slot) begin
                tick(p / 2);
                rst_n = 1'b0;
                rif.RX_IN = 1'b1;
                return;
            end
            if (scramble && s == 2) begin
                rif.PAR_EN   = ~pen;
                rif.PAR_TYP  = ~ptyp;
                rif.Prescale = (p == 8) ? 6'd16 : 6'd8;
            end
            tick(p);
        end
        rif.RX_IN = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        rif.RX_IN    = 1'b1;
        rif.PAR_EN   = 1'b0;
        rif.PAR_TYP  = 1'b0;
        rif.Prescale = 6'd8;
        tick(3);
        rst_n = 1'b1;
        idle(5);

        // Prescale 8, no parity, 0xA5
        send_frame(8'hA5, 1'b0, 1'b0, 8, 1'b0, 1'b1, 1'b0, -1);
        idle(10);
        chk("t1_latency", dv_pe[$] + 1 - last_d, 80);
        chk("t1_pdata", rif.P_DATA, 8'hA5);

        // Prescale 16, even parity, 0x3C good then bad parity
        send_frame(8'h3C, 1'b1, 1'b0, 16, 1'b0, 1'b1, 1'b0, -1);
        idle(10);
        chk("t2_latency", dv_pe[$] + 1 - last_d, 176);
        chk("t2_pdata", rif.P_DATA, 8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, 16, 1'b1, 1'b1, 1'b0, -1);
        idle(10);
        chk("t2_par_cnt", n_par, 1);
        chk("t2_pdata_hold", rif.P_DATA, 8'h3C);
        chk("t2_dv_cnt", n_dv, 2);

        // Prescale 32, odd parity, stop bit 0; then parity and stop both bad
        send_frame(8'h00, 1'b1, 1'b1, 32, 1'b0, 1'b0, 1'b0, -1);
        idle(60);
        chk("t3_stp_cnt", n_stp, 1);
        chk("t3_pdata_hold", rif.P_DATA, 8'h3C);
        send_frame(8'h00, 1'b1, 1'b1, 32, 1'b1, 1'b0, 1'b0, -1);
        idle(60);
        chk("t3_both_stp", n_stp, 2);
        chk("t3_both_par", n_par, 1);

        // 3-cycle glitch on idle line, then a real frame
        rif.Prescale = 6'd16;
        rif.PAR_EN   = 1'b0;
        rif.RX_IN    = 1'b0;
        tick(3);
        idle(20);
        send_frame(8'h5A, 1'b0, 1'b0, 16, 1'b0, 1'b1, 1'b0, -1);
        idle(10);
        chk("t4_pdata", rif.P_DATA, 8'h5A);
        chk("t4_dv_cnt", n_dv, 3);

        // Back-to-back frames
        send_frame(8'h11, 1'b0, 1'b0, 8, 1'b0, 1'b1, 1'b0, -1);
        send_frame(8'hEE, 1'b0, 1'b0, 8, 1'b0, 1'b1, 1'b0, -1);
        idle(10);
        chk("t5_spacing", dv_pe[$] - dv_pe[$-1], 80);
        chk("t5_pdata", rif.P_DATA, 8'hEE);

        // Config changed mid-frame must not affect that frame
        send_frame(8'h96, 1'b0, 1'b0, 8, 1'b0, 1'b1, 1'b1, -1);
        idle(40);
        chk("t6_latched_cfg", rif.P_DATA, 8'h96);

        // Reset during data bit 4, then 0x81
        send_frame(8'hC3, 1'b0, 1'b0, 8, 1'b0, 1'b1, 1'b0, 5);
        tick(5);
        chk("t7_rst_pdata", rif.P_DATA, 8'h00);
        rst_n = 1'b1;
        idle(10);
        send_frame(8'h81, 1'b0, 1'b0, 8, 1'b0, 1'b1, 1'b0, -1);
        idle(10);
        chk("t7_pdata", rif.P_DATA, 8'h81);
        chk("t7_dv_cnt", n_dv, 7);

        chk("events_consumed", evq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
